// File: rtl/signed_frame_accum_pkg.sv
// rtl/signed_frame_accum_pkg.sv - shared types and signed-range helpers for the frame accumulator
package signed_frame_accum_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Sign-extend the low w bits of d to 32 bits.
    function automatic logic signed [31:0] sext(input logic [31:0] d, input int w);
        logic signed [31:0] t;
        t = signed'(d << (32 - w));
        return t >>> (32 - w);
    endfunction

    // Largest value representable in a w-bit two's-complement word.
    function automatic int acc_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit two's-complement word.
    function automatic int acc_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/signed_frame_accumulator_sadd.sv
// rtl/signed_frame_accumulator_sadd.sv - combinational signed add with overflow detect and clamp
module sadd_ovf_w
    import signed_frame_accum_pkg::*;
#(
    parameter int W = 6
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic signed [W-1:0] sat_sum,
    output logic                ovf
);

    localparam logic signed [W-1:0] MAXV = W'(acc_max(W));
    localparam logic signed [W-1:0] MINV = W'(acc_min(W));

    // Overflow only when both operands share a sign the wrapped result lacks;
    // the clamp direction follows the operands' common sign.
    always_comb begin
        sum     = a + b;
        ovf     = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        sat_sum = ovf ? (a[W-1] ? MINV : MAXV) : sum;
    end

endmodule

// File: rtl/signed_frame_accumulator.sv
// rtl/signed_frame_accumulator.sv - frame summing accumulator with sticky overflow and beat count
module signed_frame_accumulator
    import signed_frame_accum_pkg::*;
#(
    parameter int W        = 4,
    parameter int ACC_W    = 6,
    parameter int CNT_W    = 4,
    parameter int SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_ovf,
    output logic [CNT_W-1:0]        out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                  state;
    state_e                  state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf;
    logic [CNT_W-1:0]        cnt;

    logic signed [ACC_W-1:0] samp_ext;
    logic signed [ACC_W-1:0] add_sum;
    logic signed [ACC_W-1:0] add_sat;
    logic                    add_ovf;
    logic                    beat;
    logic                    done;

    assign samp_ext = ACC_W'(sext(32'(in_data), W));

    sadd_ovf_w #(
        .W (ACC_W)
    ) u_sadd (
        .a       (acc),
        .b       (samp_ext),
        .sum     (add_sum),
        .sat_sum (add_sat),
        .ovf     (add_ovf)
    );

    assign beat = in_valid & in_ready;
    assign done = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs: accept beats in ACC, present the result in HOLD.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    // Frame datapath: accumulate on each beat, clear once the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (beat) begin
            acc <= (SATURATE != 0) ? add_sat : add_sum;
            if (add_ovf) begin
                ovf <= 1'b1;
            end
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (done) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end
    end

    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_count = cnt;

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// tb/tb_signed_frame_accumulator.sv - self-checking bench for signed_frame_accumulator
module tb_signed_frame_accumulator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [3:0]        in_data;
    logic              in_last;
    logic              out_ready;

    logic              in_ready_s, out_valid_s, out_ovf_s;
    logic signed [5:0] out_sum_s;
    logic [3:0]        out_count_s;
    logic              in_ready_w, out_valid_w, out_ovf_w;
    logic signed [5:0] out_sum_w;
    logic [3:0]        out_count_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] fbuf [0:31];
    int         flen;

    typedef struct {
        int          len;
        logic [63:0] data;
        int          exp_sat;
        int          exp_wrap;
        int          exp_ovf;
        int          exp_cnt;
        int          bp;
    } vec_t;

    vec_t vecs [8];

    signed_frame_accumulator #(.W(4), .ACC_W(6), .CNT_W(4), .SATURATE(1)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_sum   (out_sum_s),
        .out_ovf   (out_ovf_s),
        .out_count (out_count_s)
    );

    signed_frame_accumulator #(.W(4), .ACC_W(6), .CNT_W(4), .SATURATE(0)) u_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .out_sum   (out_sum_w),
        .out_ovf   (out_ovf_w),
        .out_count (out_count_w)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: integer running sum, range-checked against the 6-bit signed range.
    task automatic model(input int sat, output int sum, output int ovf, output int cnt);
        sum = 0;
        ovf = 0;
        for (int i = 0; i < flen; i++) begin
            sum = sum + int'($signed(fbuf[i]));
            if (sum > 31) begin
                ovf = 1;
                sum = sat ? 31 : sum - 64;
            end else if (sum < -32) begin
                ovf = 1;
                sum = sat ? -32 : sum + 64;
            end
        end
        cnt = (flen > 15) ? 15 : flen;
    endtask

    task automatic check_outputs(input string tag, input int es, input int ew, input int eo, input int ec);
        chk({tag, "_valid_s"}, out_valid_s, 1);
        chk({tag, "_valid_w"}, out_valid_w, 1);
        chk({tag, "_in_ready"}, in_ready_s | in_ready_w, 0);
        chk({tag, "_sum_s"}, out_sum_s, es);
        chk({tag, "_sum_w"}, out_sum_w, ew);
        chk({tag, "_ovf_s"}, out_ovf_s, eo);
        chk({tag, "_ovf_w"}, out_ovf_w, eo);
        chk({tag, "_cnt_s"}, out_count_s, ec);
        chk({tag, "_cnt_w"}, out_count_w, ec);
    endtask

    // Send fbuf[0..flen-1] as one frame, hold the result bp cycles with a pending
    // input beat, then complete the handshake with in_valid still high.
    task automatic do_frame(input string tag, input int es, input int ew, input int eo, input int ec, input int bp);
        for (int i = 0; i < flen; i++) begin
            in_valid = 1'b1;
            in_data  = fbuf[i];
            in_last  = (i == flen - 1);
            chk({tag, "_beat_ready"}, in_ready_s & in_ready_w, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_outputs(tag, es, ew, eo, ec);
        in_valid = 1'b1;
        in_data  = 4'd7;
        in_last  = 1'b1;
        for (int c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            check_outputs({tag, "_bp"}, es, ew, eo, ec);
        end
        out_ready = 1'b1;
        in_last   = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_post_valid"}, out_valid_s | out_valid_w, 0);
        chk({tag, "_post_ready"}, in_ready_s & in_ready_w, 1);
    endtask

    initial begin
        int es, ew, eo, ec;

        vecs[0] = '{3,  64'h0000_0000_0000_0E43, 5,   5,   0, 3,  0};
        vecs[1] = '{5,  64'h0000_0000_0007_7777, 31,  -29, 1, 5,  0};
        vecs[2] = '{4,  64'h0000_0000_0000_8888, -32, -32, 0, 4,  1};
        vecs[3] = '{5,  64'h0000_0000_0008_8888, -32, 24,  1, 5,  0};
        vecs[4] = '{6,  64'h0000_0000_0087_7777, 23,  27,  1, 6,  0};
        vecs[5] = '{3,  64'h0000_0000_0000_0FFF, -3,  -3,  0, 3,  3};
        vecs[6] = '{16, 64'h1111_1111_1111_1111, 16,  16,  0, 15, 0};
        vecs[7] = '{1,  64'h0000_0000_0000_0001, 1,   1,   0, 1,  0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid_s | out_valid_w, 0);
        chk("rst_ready", in_ready_s & in_ready_w, 1);
        chk("rst_sum", out_sum_s, 0);
        chk("rst_ovf", out_ovf_s, 0);
        chk("rst_cnt", out_count_s, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            flen = vecs[v].len;
            for (int i = 0; i < flen; i++) fbuf[i] = vecs[v].data[4*i +: 4];
            do_frame($sformatf("vec%0d", v), vecs[v].exp_sat, vecs[v].exp_wrap,
                     vecs[v].exp_ovf, vecs[v].exp_cnt, vecs[v].bp);
        end

        // Reset in the middle of a frame.
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 4'd2;
        @(posedge clk); #1;
        in_data  = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_valid", out_valid_s | out_valid_w, 0);
        chk("midrst_ready", in_ready_s & in_ready_w, 1);
        chk("midrst_sum", out_sum_s, 0);
        chk("midrst_cnt", out_count_s, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        flen = 1;
        fbuf[0] = 4'd1;
        do_frame("after_rst", 1, 1, 0, 1, 0);

        // Back-to-back single-beat frames with the consumer always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_data   = 4'd5;
        chk("b2b_ready0", in_ready_s, 1);
        @(posedge clk); #1;
        chk("b2b_valid0", out_valid_s, 1);
        chk("b2b_sum0", out_sum_s, 5);
        chk("b2b_cnt0", out_count_s, 1);
        chk("b2b_ready1", in_ready_s, 0);
        in_data = 4'hA;
        @(posedge clk); #1;
        chk("b2b_valid1", out_valid_s, 0);
        chk("b2b_ready2", in_ready_s, 1);
        @(posedge clk); #1;
        chk("b2b_valid2", out_valid_s, 1);
        chk("b2b_sum2", out_sum_s, -6);
        chk("b2b_sum2w", out_sum_w, -6);
        chk("b2b_cnt2", out_count_s, 1);
        chk("b2b_ready3", in_ready_s, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
        chk("b2b_valid3", out_valid_s, 0);
        out_ready = 1'b0;

        // Randomized frames against the integer reference.
        for (int f = 0; f < 40; f++) begin
            flen = $urandom_range(1, 20);
            for (int i = 0; i < flen; i++) fbuf[i] = 4'($urandom_range(0, 15));
            model(1, es, eo, ec);
            model(0, ew, eo, ec);
            do_frame($sformatf("rnd%0d", f), es, ew, eo, ec, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
